// File: rtl/pit_pkg.sv
// pit_pkg -- shared definitions for the PIT command controller.
// Holds the command opcode encodings, the command FSM state encoding and
// the compare value the timer is loaded with out of reset.
package pit_pkg;

  // Top two bits of a command byte select the operation.
  typedef enum logic [1:0] {
    OP_NOP   = 2'b00,
    OP_LOAD  = 2'b01,
    OP_CLEAR = 2'b10,
    OP_FLAGS = 2'b11
  } pit_op_e;

  // Command FSM: a LOAD walks through the two data bytes and a one-cycle
  // commit; everything else finishes in IDLE.
  typedef enum logic [1:0] {
    IDLE     = 2'b00,
    GET_HIGH = 2'b01,
    GET_LOW  = 2'b10,
    COMMIT   = 2'b11
  } pit_state_e;

  localparam logic [15:0] PIT_RESET_COUNT = 16'd10;

endpackage

// File: rtl/pit_irq_track.sv
// pit_irq_track -- timer interrupt bookkeeping.
// Detects rising edges of the timer interrupt line, keeps a sticky pending
// flag, a sticky overrun flag (edge while already pending) and a saturating
// count of edges seen.
// Ports:
//   clk, reset          clock and synchronous active-high reset
//   pit_interrupting    raw timer interrupt level (may be several cycles wide)
//   irq_ack             clears irq and irq_overrun
//   clear_all           clears irq, irq_overrun and irq_count
//   irq, irq_overrun    sticky flags
//   irq_count           saturating edge counter, COUNT_W bits
module pit_irq_track
  import pit_pkg::*;
#(
  parameter int COUNT_W = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               pit_interrupting,
  input  logic               irq_ack,
  input  logic               clear_all,
  output logic               irq,
  output logic               irq_overrun,
  output logic [COUNT_W-1:0] irq_count
);

  localparam logic [COUNT_W-1:0] COUNT_MAX = '1;
  localparam logic [COUNT_W-1:0] COUNT_ONE = COUNT_W'(1);

  logic prev_int;
  logic rise;
  logic clear_flags;

  assign rise        = pit_interrupting & ~prev_int;
  assign clear_flags = irq_ack | clear_all;

  // A new edge always beats a clear arriving in the same cycle, so the
  // clear paths load the edge value rather than plain zero.
  always_ff @(posedge clk) begin
    if (reset) begin
      prev_int    <= 1'b0;
      irq         <= 1'b0;
      irq_overrun <= 1'b0;
      irq_count   <= '0;
    end else begin
      prev_int <= pit_interrupting;
      if (clear_flags) begin
        irq         <= rise;
        irq_overrun <= 1'b0;
      end else begin
        irq         <= irq | rise;
        irq_overrun <= irq_overrun | (rise & irq);
      end
      if (clear_all) begin
        irq_count <= rise ? COUNT_ONE : '0;
      end else if (rise && (irq_count != COUNT_MAX)) begin
        irq_count <= irq_count + 1'b1;
      end
    end
  end

endmodule

// File: rtl/pit_cmd_ctrl.sv
// pit_cmd_ctrl -- byte-stream command decoder for a programmable timer.
// Commands: NOP, LOAD (two data bytes, high then low, then a one-cycle
// commit pulse on pit_write_enable), CLEAR (interrupt bookkeeping) and
// FLAGS (repeating / divider mode bits only).
// Ports:
//   clk, reset                         clock and synchronous active-high reset
//   cmd_valid, cmd_data, cmd_ready     command byte stream (valid/ready)
//   pit_write_enable                   high for the single commit cycle
//   pit_counter_high, pit_counter_low  registered compare value
//   pit_repeating, pit_divider_on      registered mode flags
//   pit_interrupting                   timer interrupt input
//   irq, irq_ack, irq_overrun          sticky interrupt status and its clear
//   irq_count                          saturating interrupt edge count
module pit_cmd_ctrl
  import pit_pkg::*;
#(
  parameter int          COUNT_W     = 8,
  parameter logic [15:0] RESET_COUNT = PIT_RESET_COUNT
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               cmd_valid,
  input  logic [7:0]         cmd_data,
  output logic               cmd_ready,
  output logic               pit_write_enable,
  output logic [7:0]         pit_counter_high,
  output logic [7:0]         pit_counter_low,
  output logic               pit_repeating,
  output logic               pit_divider_on,
  input  logic               pit_interrupting,
  output logic               irq,
  input  logic               irq_ack,
  output logic               irq_overrun,
  output logic [COUNT_W-1:0] irq_count
);

  pit_state_e state, next_state;
  pit_op_e    op;
  logic       accept;
  logic       clear_cmd;
  logic [7:0] staged_high;
  logic       staged_r;
  logic       staged_d;

  assign op     = pit_op_e'(cmd_data[7:6]);
  assign accept = cmd_valid & cmd_ready;

  // Next-state and handshake decode. Ready and write-enable are gated by
  // reset so nothing can be accepted or committed while reset is held.
  always_comb begin
    next_state       = state;
    cmd_ready        = 1'b0;
    pit_write_enable = 1'b0;
    clear_cmd        = 1'b0;
    case (state)
      IDLE: begin
        cmd_ready = ~reset;
        if (accept) begin
          case (op)
            OP_LOAD:  next_state = GET_HIGH;
            OP_CLEAR: clear_cmd  = 1'b1;
            default:  next_state = IDLE;
          endcase
        end
      end
      GET_HIGH: begin
        cmd_ready = ~reset;
        if (accept) next_state = GET_LOW;
      end
      GET_LOW: begin
        cmd_ready = ~reset;
        if (accept) next_state = COMMIT;
      end
      COMMIT: begin
        pit_write_enable = ~reset;
        next_state       = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // State, staging and timer output registers. The pit outputs are loaded
  // on the edge that accepts the low byte, so the new values are already on
  // the outputs during the COMMIT cycle that pulses pit_write_enable.
  always_ff @(posedge clk) begin
    if (reset) begin
      state            <= IDLE;
      staged_high      <= 8'h00;
      staged_r         <= 1'b0;
      staged_d         <= 1'b0;
      pit_counter_high <= RESET_COUNT[15:8];
      pit_counter_low  <= RESET_COUNT[7:0];
      pit_repeating    <= 1'b1;
      pit_divider_on   <= 1'b0;
    end else begin
      state <= next_state;
      if (accept) begin
        case (state)
          IDLE: begin
            if (op == OP_LOAD) begin
              staged_r <= cmd_data[0];
              staged_d <= cmd_data[1];
            end else if (op == OP_FLAGS) begin
              pit_repeating  <= cmd_data[0];
              pit_divider_on <= cmd_data[1];
            end
          end
          GET_HIGH: staged_high <= cmd_data;
          GET_LOW: begin
            pit_counter_high <= staged_high;
            pit_counter_low  <= cmd_data;
            pit_repeating    <= staged_r;
            pit_divider_on   <= staged_d;
          end
          default: ;
        endcase
      end
    end
  end

  pit_irq_track #(
    .COUNT_W (COUNT_W)
  ) u_irq_track (
    .clk              (clk),
    .reset            (reset),
    .pit_interrupting (pit_interrupting),
    .irq_ack          (irq_ack),
    .clear_all        (clear_cmd),
    .irq              (irq),
    .irq_overrun      (irq_overrun),
    .irq_count        (irq_count)
  );

endmodule

// File: tb/tb_pit_cmd_ctrl.sv
// tb_pit_cmd_ctrl -- self-checking bench for pit_cmd_ctrl.
// Two instances share all inputs: one with the default 8-bit event counter
// and one with a 2-bit counter to exercise saturation. A behavioural model
// tracks expected outputs and is compared on every falling edge; directed
// sequences add hand-computed literal checks, followed by a random phase.
module tb_pit_cmd_ctrl;

  logic       clk;
  logic       reset;
  logic       cmd_valid;
  logic [7:0] cmd_data;
  logic       pit_interrupting;
  logic       irq_ack;

  logic       cmd_ready, pit_write_enable, pit_repeating, pit_divider_on;
  logic [7:0] pit_counter_high, pit_counter_low;
  logic       irq, irq_overrun;
  logic [7:0] irq_count;

  logic       cmd_ready2, pit_write_enable2, pit_repeating2, pit_divider_on2;
  logic [7:0] pit_counter_high2, pit_counter_low2;
  logic       irq2, irq_overrun2;
  logic [1:0] irq_count2;

  int nAssert = 0;
  int nFail   = 0;
  bit checkEn = 0;

  pit_cmd_ctrl dut (
    .clk              (clk),
    .reset            (reset),
    .cmd_valid        (cmd_valid),
    .cmd_data         (cmd_data),
    .cmd_ready        (cmd_ready),
    .pit_write_enable (pit_write_enable),
    .pit_counter_high (pit_counter_high),
    .pit_counter_low  (pit_counter_low),
    .pit_repeating    (pit_repeating),
    .pit_divider_on   (pit_divider_on),
    .pit_interrupting (pit_interrupting),
    .irq              (irq),
    .irq_ack          (irq_ack),
    .irq_overrun      (irq_overrun),
    .irq_count        (irq_count)
  );

  pit_cmd_ctrl #(.COUNT_W(2)) dut2 (
    .clk              (clk),
    .reset            (reset),
    .cmd_valid        (cmd_valid),
    .cmd_data         (cmd_data),
    .cmd_ready        (cmd_ready2),
    .pit_write_enable (pit_write_enable2),
    .pit_counter_high (pit_counter_high2),
    .pit_counter_low  (pit_counter_low2),
    .pit_repeating    (pit_repeating2),
    .pit_divider_on   (pit_divider_on2),
    .pit_interrupting (pit_interrupting),
    .irq              (irq2),
    .irq_ack          (irq_ack),
    .irq_overrun      (irq_overrun2),
    .irq_count        (irq_count2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural model: a LOAD is "two more bytes wanted, then one busy
  // cycle"; interrupt status is plain flags and integer counters.
  int         bytesWanted = 0;
  bit         busyCycle   = 0;
  bit         stR = 0, stD = 0;
  logic [7:0] stHi = 8'h00;
  logic [7:0] mHi = 8'h00, mLo = 8'd10;
  bit         mR = 1, mD = 0;
  bit         mPrev = 0, mIrq = 0, mOvr = 0;
  int         mCnt8 = 0, mCnt2 = 0;

  always @(posedge clk) begin : modelProc
    bit clr;
    bit rise;
    clr = 0;
    if (reset) begin
      bytesWanted = 0;
      busyCycle   = 0;
      mHi = 8'h00; mLo = 8'd10; mR = 1; mD = 0;
      mPrev = 0; mIrq = 0; mOvr = 0; mCnt8 = 0; mCnt2 = 0;
      checkEn = 1;
    end else begin
      if (busyCycle) begin
        busyCycle = 0;
      end else if (cmd_valid) begin
        if (bytesWanted == 2) begin
          stHi = cmd_data;
          bytesWanted = 1;
        end else if (bytesWanted == 1) begin
          mHi = stHi; mLo = cmd_data; mR = stR; mD = stD;
          bytesWanted = 0;
          busyCycle = 1;
        end else begin
          case (cmd_data[7:6])
            2'b01: begin bytesWanted = 2; stR = cmd_data[0]; stD = cmd_data[1]; end
            2'b10: clr = 1;
            2'b11: begin mR = cmd_data[0]; mD = cmd_data[1]; end
            default: ;
          endcase
        end
      end
      rise  = pit_interrupting && !mPrev;
      mPrev = pit_interrupting;
      if (clr || irq_ack) begin
        mOvr = 0;
        mIrq = rise;
      end else begin
        mOvr = mOvr || (rise && mIrq);
        mIrq = mIrq || rise;
      end
      if (clr) begin
        mCnt8 = rise ? 1 : 0;
        mCnt2 = rise ? 1 : 0;
      end else if (rise) begin
        mCnt8 = (mCnt8 < 255) ? mCnt8 + 1 : 255;
        mCnt2 = (mCnt2 < 3) ? mCnt2 + 1 : 3;
      end
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    nAssert++;
    if (actual !== expected) begin
      nFail++;
      $display("[TB] FAIL %s at %0t: got %0h expected %0h", name, $time, actual, expected);
    end
  endtask

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (checkEn) begin
      checkOutput("cmd_ready", 32'(cmd_ready), 32'(!reset && !busyCycle));
      checkOutput("write_enable", 32'(pit_write_enable), 32'(!reset && busyCycle));
      checkOutput("counter_high", 32'(pit_counter_high), 32'(mHi));
      checkOutput("counter_low", 32'(pit_counter_low), 32'(mLo));
      checkOutput("repeating", 32'(pit_repeating), 32'(mR));
      checkOutput("divider_on", 32'(pit_divider_on), 32'(mD));
      checkOutput("irq", 32'(irq), 32'(mIrq));
      checkOutput("irq_overrun", 32'(irq_overrun), 32'(mOvr));
      checkOutput("irq_count", 32'(irq_count), 32'(mCnt8));
      checkOutput("irq_count_w2", 32'(irq_count2), 32'(mCnt2));
      checkOutput("write_enable_w2", 32'(pit_write_enable2), 32'(pit_write_enable));
    end
  end

  // Drives one cycle of inputs and returns just after the edge that sampled them.
  task automatic applyStimulus(input logic rst, input logic v, input logic [7:0] d,
                               input logic i, input logic a);
    reset = rst; cmd_valid = v; cmd_data = d; pit_interrupting = i; irq_ack = a;
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1; cmd_valid = 1'b0; cmd_data = 8'h00;
    pit_interrupting = 1'b0; irq_ack = 1'b0;

    // Reset values
    repeat (3) applyStimulus(1, 1, 8'h41, 0, 0);
    checkOutput("rst_ready", 32'(cmd_ready), 0);
    checkOutput("rst_we", 32'(pit_write_enable), 0);
    checkOutput("rst_counter", 32'({pit_counter_high, pit_counter_low}), 32'd10);
    checkOutput("rst_repeating", 32'(pit_repeating), 1);
    checkOutput("rst_divider", 32'(pit_divider_on), 0);
    checkOutput("rst_irq", 32'({irq, irq_overrun, irq_count}), 0);

    // FLAGS 0xC2
    applyStimulus(0, 1, 8'hC2, 0, 0);
    checkOutput("flags_repeating", 32'(pit_repeating), 0);
    checkOutput("flags_divider", 32'(pit_divider_on), 1);
    checkOutput("flags_we", 32'(pit_write_enable), 0);
    checkOutput("flags_counter", 32'({pit_counter_high, pit_counter_low}), 32'd10);
    applyStimulus(0, 0, 8'h00, 0, 0);
    checkOutput("flags_we_after", 32'(pit_write_enable), 0);

    // LOAD 0x41, 0x12, 0x34 with valid held: commit cycle follows the low byte
    applyStimulus(0, 1, 8'h41, 0, 0);
    applyStimulus(0, 1, 8'h12, 0, 0);
    checkOutput("load_we_early", 32'(pit_write_enable), 0);
    applyStimulus(0, 1, 8'h34, 0, 0);
    checkOutput("load_we", 32'(pit_write_enable), 1);
    checkOutput("load_ready", 32'(cmd_ready), 0);
    checkOutput("load_counter", 32'({pit_counter_high, pit_counter_low}), 32'h1234);
    checkOutput("load_repeating", 32'(pit_repeating), 1);
    checkOutput("load_divider", 32'(pit_divider_on), 0);
    applyStimulus(0, 0, 8'h00, 0, 0);
    checkOutput("load_we_single", 32'(pit_write_enable), 0);
    checkOutput("load_ready_back", 32'(cmd_ready), 1);
    checkOutput("load_counter_hold", 32'({pit_counter_high, pit_counter_low}), 32'h1234);

    // Three pulses without ack, then ack
    repeat (3) begin
      applyStimulus(0, 0, 8'h00, 1, 0);
      applyStimulus(0, 0, 8'h00, 0, 0);
    end
    checkOutput("pulses_irq", 32'(irq), 1);
    checkOutput("pulses_overrun", 32'(irq_overrun), 1);
    checkOutput("pulses_count", 32'(irq_count), 3);
    applyStimulus(0, 0, 8'h00, 0, 1);
    checkOutput("ack_irq", 32'(irq), 0);
    checkOutput("ack_overrun", 32'(irq_overrun), 0);
    checkOutput("ack_count", 32'(irq_count), 3);

    // Edge coincident with CLEAR: set wins
    applyStimulus(0, 1, 8'h80, 1, 0);
    checkOutput("clr_edge_irq", 32'(irq), 1);
    checkOutput("clr_edge_overrun", 32'(irq_overrun), 0);
    checkOutput("clr_edge_count", 32'(irq_count), 1);
    applyStimulus(0, 0, 8'h00, 0, 0);

    // Saturation of the 2-bit counter, and a long high level counts once
    applyStimulus(0, 1, 8'h80, 0, 0);
    repeat (5) begin
      applyStimulus(0, 0, 8'h00, 1, 0);
      applyStimulus(0, 0, 8'h00, 0, 0);
    end
    checkOutput("sat_count_w2", 32'(irq_count2), 3);
    checkOutput("sat_count_w8", 32'(irq_count), 5);
    applyStimulus(0, 1, 8'h80, 0, 0);
    repeat (20) applyStimulus(0, 0, 8'h00, 1, 0);
    checkOutput("held_count", 32'(irq_count), 1);
    checkOutput("held_count_w2", 32'(irq_count2), 1);
    applyStimulus(0, 0, 8'h00, 0, 0);

    // Reset in the middle of a LOAD discards it
    applyStimulus(0, 1, 8'h41, 0, 0);
    applyStimulus(0, 1, 8'hAA, 0, 0);
    applyStimulus(1, 0, 8'h00, 0, 0);
    checkOutput("midrst_ready", 32'(cmd_ready), 0);
    checkOutput("midrst_we", 32'(pit_write_enable), 0);
    applyStimulus(0, 1, 8'h00, 0, 0);
    repeat (3) begin
      checkOutput("midrst_we_after", 32'(pit_write_enable), 0);
      applyStimulus(0, 0, 8'h00, 0, 0);
    end
    checkOutput("midrst_counter", 32'({pit_counter_high, pit_counter_low}), 32'd10);

    // Random traffic checked by the per-cycle model comparison
    for (int n = 0; n < 2000; n++) begin
      logic       rst, v, intr, a;
      logic [7:0] d;
      rst  = ($urandom_range(0, 99) < 2);
      v    = ($urandom_range(0, 2) != 0);
      d    = 8'($urandom_range(0, 255));
      intr = ($urandom_range(0, 3) == 0) ? ~pit_interrupting : pit_interrupting;
      a    = ($urandom_range(0, 11) == 0);
      applyStimulus(rst, v, d, intr, a);
    end

    applyStimulus(0, 0, 8'h00, 0, 0);
    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", nAssert, nFail);
    $finish;
  end

endmodule

// File: doc/pit_cmd_ctrl.md
PIT_CMD_CTRL -- requirements
Module: pit_cmd_ctrl

Interface
REQ-001 SHALL have parameter COUNT_W, default 8: width of interrupt event counter.
REQ-002 SHALL have parameter RESET_COUNT, default 16'd10: compare value driven on pit_counter_{high,low} after reset.
REQ-003 SHALL have port clk  in  1  single clock; all logic on rising edge.
REQ-004 SHALL have port reset  in  1  synchronous, active-high reset.
REQ-005 SHALL have ports cmd_valid  in  1 / cmd_data  in  8 / cmd_ready  out  1  byte-wide command stream; a byte transfers when cmd_valid && cmd_ready.
REQ-006 SHALL have ports pit_write_enable  out  1 / pit_counter_high  out  8 / pit_counter_low  out  8  timer compare-value load.
REQ-007 SHALL have ports pit_repeating  out  1 / pit_divider_on  out  1  timer mode flags.
REQ-008 SHALL have port pit_interrupting  in  1  timer interrupt, may be one or more cycles wide.
REQ-009 SHALL have ports irq  out  1 (sticky pending) / irq_ack  in  1 (clear) / irq_overrun  out  1 (sticky) / irq_count  out  COUNT_W (events seen).

Function
REQ-010 Command byte SHALL decode as op=cmd_data[7:6], R=cmd_data[0] (repeating), D=cmd_data[1] (divider_on).
REQ-011 Opcodes SHALL be: 00 NOP; 01 LOAD (followed by HIGH byte, then LOW byte); 10 CLEAR (clear irq, irq_overrun, irq_count); 11 FLAGS (update R/D only).
REQ-012 FSM states SHALL be IDLE, GET_HIGH, GET_LOW, COMMIT.
REQ-013 IDLE: LOAD byte -> GET_HIGH, staging R/D; any other opcode executes in the accept cycle and stays in IDLE.
REQ-014 GET_HIGH: accepted byte -> staged high, -> GET_LOW. GET_LOW: accepted byte -> staged low, -> COMMIT.
REQ-015 COMMIT SHALL last exactly one cycle, drive cmd_ready=0, assert pit_write_enable=1, and present staged high/low/R/D on the pit outputs in that same cycle; then -> IDLE.
REQ-016 pit_counter_high/low, pit_repeating and pit_divider_on SHALL be registered and SHALL hold their values until the next COMMIT (or FLAGS for R/D).
REQ-017 cmd_ready SHALL be 1 in IDLE, GET_HIGH and GET_LOW, and 0 in COMMIT; bytes presented while cmd_valid=0 SHALL be ignored with no state change.
REQ-018 A FLAGS command SHALL update pit_repeating/pit_divider_on the cycle after accept and SHALL NOT pulse pit_write_enable.
REQ-019 A rising edge of pit_interrupting (registered previous sample 0, current 1) SHALL set irq on the next cycle and increment irq_count, saturating at all-ones.
REQ-020 A rising edge while irq is already 1 SHALL set irq_overrun.
REQ-021 irq_ack=1 SHALL clear irq and irq_overrun only; irq_count SHALL be unchanged.
REQ-022 If a rising edge and a clear (irq_ack or CLEAR) occur in the same cycle, the set SHALL win: irq=1, irq_overrun=0, irq_count=1 for CLEAR, or incremented for irq_ack.
REQ-023 A held-high pit_interrupting SHALL count once per rising edge only.

Reset
REQ-024 While reset=1, state SHALL be IDLE, cmd_ready=0, pit_write_enable=0, and irq=irq_overrun=irq_count=0.
REQ-025 While reset=1, pit_counter_high/low SHALL be RESET_COUNT, pit_repeating=1, pit_divider_on=0, and the edge-detect register SHALL be 0.
REQ-026 Reset asserted mid-LOAD SHALL discard staged bytes, with no pit_write_enable pulse.

Structure
REQ-027 Opcode encodings, FSM state encodings and RESET_COUNT default SHALL live in shared package pit_pkg.
REQ-028 Interrupt edge-detect, sticky and counter logic SHALL be sub-module pit_irq_track; the FSM stays in pit_cmd_ctrl.

Verification
REQ-029 After reset, bytes 0x41, 0x12, 0x34 with cmd_valid held -> pit_write_enable is a single pulse in cycle 4, counter=0x1234, repeating=1, divider_on=0, and cmd_ready=0 in that cycle.
REQ-030 Byte 0xC2 -> repeating=0, divider_on=1 next cycle, no write_enable pulse, counter unchanged at 10.
REQ-031 Three pit_interrupting pulses with no ack -> irq=1, irq_overrun=1, irq_count=3; then irq_ack -> irq=0, irq_overrun=0, irq_count=3.
REQ-032 Rising edge coincident with CLEAR (0x80) -> irq=1, irq_overrun=0, irq_count=1.
REQ-033 0x41, 0xAA, then reset, then 0x00 -> no write_enable pulse; counter remains 10.
REQ-034 COUNT_W=2 with five edges -> irq_count saturates at 3; pit_interrupting held high for 20 cycles -> one count.
